// File: rtl/fc_layer_seq_if.sv
// Job/result handshake bundle for the sequential fully-connected layer.
// master drives operands and accepts results; slave is the layer itself.
interface fc_layer_seq_if #(
  parameter int unsigned BATCH_SIZE = 1,
  parameter int unsigned FEAT_SIZE  = 3,
  parameter int unsigned OUT_SIZE   = 2,
  parameter int unsigned DW         = 32
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [BATCH_SIZE*FEAT_SIZE*DW-1:0]    data;
  logic [FEAT_SIZE*OUT_SIZE*DW-1:0]      weight;
  logic [OUT_SIZE*DW-1:0]                bias;
  logic                                  relu_en;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [BATCH_SIZE*OUT_SIZE*DW-1:0]     result;
  logic                                  busy;

  modport master (
    output in_valid, data, weight, bias, relu_en, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, data, weight, bias, relu_en, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: OUT_SIZE MAC lanes stepped over (b,k),
// then one bias/shift/ReLU/saturate pass into a held result register.
module fc_layer_seq #(
  parameter int unsigned BATCH_SIZE = 1,
  parameter int unsigned FEAT_SIZE  = 3,
  parameter int unsigned OUT_SIZE   = 2,
  parameter int unsigned DW         = 32,
  parameter int unsigned FRAC       = 0
) (
  input  logic          clk,
  input  logic          rst,
  fc_layer_seq_if.slave bus
);

  localparam int unsigned ACCW = 2*DW + $clog2(FEAT_SIZE+1) + 1;
  localparam int unsigned BW   = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam int unsigned KW   = (FEAT_SIZE  > 1) ? $clog2(FEAT_SIZE)  : 1;
  localparam int unsigned OW   = (OUT_SIZE   > 1) ? $clog2(OUT_SIZE)   : 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_e;

  state_e state_q, state_d;

  // Packed operand layouts match the flat bus element ordering exactly
  logic [BATCH_SIZE-1:0][FEAT_SIZE-1:0][DW-1:0]   data_q;
  logic [FEAT_SIZE-1:0][OUT_SIZE-1:0][DW-1:0]     weight_q;
  logic [OUT_SIZE-1:0][DW-1:0]                    bias_q;
  logic                                           relu_q;
  logic [BATCH_SIZE-1:0][OUT_SIZE-1:0][ACCW-1:0]  acc_q;
  logic [BATCH_SIZE-1:0][OUT_SIZE-1:0][DW-1:0]    result_q, result_d;
  logic [BW-1:0]                                  b_q;
  logic [KW-1:0]                                  k_q;
  logic                                           out_valid_q;
  logic                                           busy_q;
  logic                                           accept;
  logic                                           last_step;
  logic signed [ACCW-1:0]                         sum_t;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_step = (b_q == BW'(BATCH_SIZE-1)) && (k_q == KW'(FEAT_SIZE-1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)        state_d = MAC;
      MAC:  if (last_step)     state_d = BIAS;
      BIAS:                    state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Bias add, floor shift, optional ReLU and saturation for every lane
  always_comb begin
    result_d = '0;
    sum_t    = '0;
    for (int b = 0; b < BATCH_SIZE; b++) begin
      for (int j = 0; j < OUT_SIZE; j++) begin
        sum_t = $signed(acc_q[BW'(b)][OW'(j)])
              + (ACCW'($signed(bias_q[OW'(j)])) <<< FRAC);
        sum_t = sum_t >>> FRAC;
        if (relu_q && sum_t[ACCW-1]) sum_t = '0;
        if (sum_t > SAT_MAX)      sum_t = SAT_MAX;
        else if (sum_t < SAT_MIN) sum_t = SAT_MIN;
        result_d[BW'(b)][OW'(j)] = sum_t[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      b_q      <= '0;
      k_q      <= '0;
    end else begin
      if (accept) begin
        data_q   <= bus.data;
        weight_q <= bus.weight;
        bias_q   <= bus.bias;
        relu_q   <= bus.relu_en;
        acc_q    <= '0;
        b_q      <= '0;
        k_q      <= '0;
      end
      // Sign-extended operands keep the wrapped unsigned sum two's-complement correct
      if (state_q == MAC) begin
        for (int j = 0; j < OUT_SIZE; j++) begin
          acc_q[b_q][OW'(j)] <= acc_q[b_q][OW'(j)]
                              + ACCW'($signed(data_q[b_q][k_q]))
                              * ACCW'($signed(weight_q[k_q][OW'(j)]));
        end
        if (k_q == KW'(FEAT_SIZE-1)) begin
          k_q <= '0;
          b_q <= b_q + BW'(1);
        end else begin
          k_q <= k_q + KW'(1);
        end
      end
      if (state_q == BIAS) result_q <= result_d;
    end
  end

endmodule
